// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: decodes ALUControl, computes result/zero/err and
// buffers completed operations in a 2-entry FIFO behind valid/ready handshakes.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_err
);

    logic [WIDTH-1:0] calc_result;
    logic             calc_zero;
    logic             calc_err;
    logic             calc_lt;

    logic [WIDTH-1:0] res_q  [2];
    logic             zero_q [2];
    logic [TAGW-1:0]  tag_q  [2];
    logic             err_q  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic accept;
    logic pop;

    assign calc_lt = $signed(src_a) < $signed(src_b);

    always_comb begin
        calc_result = '0;
        calc_err    = 1'b0;
        case (alu_control)
            3'b000:  calc_result = src_a & src_b;
            3'b001:  calc_result = src_a | src_b;
            3'b010:  calc_result = src_a + src_b;
            3'b110:  calc_result = src_a - src_b;
            3'b111:  calc_result = {{(WIDTH-1){1'b0}}, calc_lt};
            default: calc_err    = 1'b1;
        endcase
        calc_zero = (calc_result == '0);
    end

    // in_ready comes only from registered count, so out_ready never reaches it
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result = res_q[rd_ptr];
    assign out_zero   = zero_q[rd_ptr];
    assign out_tag    = tag_q[rd_ptr];
    assign out_err    = err_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                tag_q[i]  <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                res_q[wr_ptr]  <= calc_result;
                zero_q[wr_ptr] <= calc_zero;
                tag_q[wr_ptr]  <= in_tag;
                err_q[wr_ptr]  <= calc_err;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage: one task per scenario, hand-computed expectations.
module tb_alu_exec_stage;

    localparam int WIDTH = 32;
    localparam int TAGW  = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic [TAGW-1:0]  out_tag;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    alu_exec_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ctrl, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
        in_valid    = 1'b1;
        alu_control = ctrl;
        src_a       = a;
        src_b       = b;
        in_tag      = tag;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = 3'b000; src_a = '0; src_b = '0; in_tag = '0;
        repeat (2) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({out_result, out_zero, out_tag, out_err} !== '0) begin failures++; $display("[TB] FAIL reset_outputs: got res=%h zero=%b tag=%0d err=%b expected all 0", out_result, out_zero, out_tag, out_err); end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_add_basic();
        out_ready = 1'b1;
        drive(3'b010, 32'd5, 32'd7, 5'd3);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_result !== 32'd12) begin failures++; $display("[TB] FAIL add_result: got %0d expected 12", out_result); end
        checks++; if (out_zero !== 1'b0) begin failures++; $display("[TB] FAIL add_zero: got %b expected 0", out_zero); end
        checks++; if (out_tag !== 5'd3) begin failures++; $display("[TB] FAIL add_tag: got %0d expected 3", out_tag); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("[TB] FAIL add_err: got %b expected 0", out_err); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_ops();
        logic [2:0]       ctrl_v [8] = '{3'b110, 3'b110, 3'b010, 3'b111, 3'b111, 3'b000, 3'b001, 3'b111};
        logic [WIDTH-1:0] a_v    [8] = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hF0F0, 32'hF0F0, 32'd4};
        logic [WIDTH-1:0] b_v    [8] = '{32'd7, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFF00, 32'h0F00, 32'd4};
        logic [WIDTH-1:0] exp_v  [8] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'hF000, 32'hFFF0, 32'd0};
        logic             zexp_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(ctrl_v[i], a_v[i], b_v[i], 5'(i + 16));
            step();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_tag !== 5'(i + 16)) begin failures++; $display("[TB] FAIL op%0d_valid_tag: got valid=%b tag=%0d expected 1/%0d", i, out_valid, out_tag, i + 16); end
            checks++; if (out_result !== exp_v[i]) begin failures++; $display("[TB] FAIL op%0d_result: got %h expected %h", i, out_result, exp_v[i]); end
            checks++; if (out_zero !== zexp_v[i] || out_err !== 1'b0) begin failures++; $display("[TB] FAIL op%0d_flags: got zero=%b err=%b expected %b/0", i, out_zero, out_err, zexp_v[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'b010, 32'd1, 32'd1, 5'd1);
        step();
        drive(3'b010, 32'd2, 32'd2, 5'd2);
        step();
        drive(3'b010, 32'd3, 32'd3, 5'd3);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full: got in_ready=%b expected 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_result !== 32'd2) begin failures++; $display("[TB] FAIL bp_hold: got in_ready=%b tag=%0d res=%0d expected 0/1/2", in_ready, out_tag, out_result); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_comb_path: got in_ready=%b expected 0", in_ready); end
        step();
        checks++; if (out_tag !== 5'd2 || out_result !== 32'd4 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_second: got tag=%0d res=%0d in_ready=%b expected 2/4/1", out_tag, out_result, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_result !== 32'd6) begin failures++; $display("[TB] FAIL bp_third: got valid=%b tag=%0d res=%0d expected 1/3/6", out_valid, out_tag, out_result); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_unsupported();
        out_ready = 1'b1;
        drive(3'b011, 32'd9, 32'd4, 5'd7);
        step();
        checks++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_err !== 1'b1 || out_tag !== 5'd7) begin failures++; $display("[TB] FAIL unsup_entry: got res=%h zero=%b err=%b tag=%0d expected 0/1/1/7", out_result, out_zero, out_err, out_tag); end
        drive(3'b010, 32'd1, 32'd2, 5'd8);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_err !== 1'b0 || out_tag !== 5'd8) begin failures++; $display("[TB] FAIL unsup_next_add: got valid=%b res=%0d err=%b tag=%0d expected 1/3/0/8", out_valid, out_result, out_err, out_tag); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(3'b001, 32'h10, 32'h01, 5'd10);
        step();
        drive(3'b001, 32'h20, 32'h02, 5'd11);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_prefill: got valid=%b in_ready=%b expected 1/0", out_valid, in_ready); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_async: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        checks++; if (out_result !== 32'd0 || out_tag !== 5'd0) begin failures++; $display("[TB] FAIL rst_async_data: got res=%h tag=%0d expected 0/0", out_result, out_tag); end
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_release_empty: got out_valid=%b expected 0", out_valid); end
        out_ready = 1'b1;
        drive(3'b010, 32'd20, 32'd22, 5'd12);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_tag !== 5'd12 || out_result !== 32'd42) begin failures++; $display("[TB] FAIL rst_first_after: got valid=%b tag=%0d res=%0d expected 1/12/42", out_valid, out_tag, out_result); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_only_one: got out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_ops();
        test_backpressure();
        test_unsupported();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
